// File: rtl/decode_pipe_stage.sv
// RV32 decode stage: opcode/ALU/immediate decode, register file, load-use stall, D->E register (DECODE_WRITE_BYPASS_EN adds W->D read bypass).
// Latency: 1 cycle from instructionF to E outputs.
// Backpressure: stallF holds fetch for one cycle on a load-use hazard; flushE and stallF both load a bubble into E.
module decode_pipe_stage #(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instructionF,
    input  logic [XLEN-1:0] PCF,
    input  logic            validF,
    input  logic            flushE,
    input  logic            RegWriteW,
    input  logic [AW-1:0]   WriteAddressW,
    input  logic [XLEN-1:0] writeDataW,
    output logic            stallF,
    output logic            validE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ReadOut1E,
    output logic [XLEN-1:0] ReadOut2E,
    output logic [XLEN-1:0] ImmGenOutE,
    output logic [AW-1:0]   Rs1E,
    output logic [AW-1:0]   Rs2E,
    output logic [AW-1:0]   WriteAddressE,
    output logic [5:0]      ALUSelectE,
    output logic            RegWriteE,
    output logic            MemReadE,
    output logic            MemWriteE,
    output logic            ImmSelectE,
    output logic            PCSelectE,
    output logic            JtypeE,
    output logic            BranchE,
    output logic            IllegalE
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [5:0]      aluSel;
        logic            regWrite;
        logic            memRead;
        logic            memWrite;
        logic            immSel;
        logic            pcSel;
        logic            jtype;
        logic            branch;
        logic            illegal;
    } eStage_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [AW-1:0]   rs1Idx;
    logic [AW-1:0]   rs2Idx;
    logic [AW-1:0]   rdIdx;
    logic [31:0]     immI, immS, immB, immU, immJ, imm32;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] readData1;
    logic [XLEN-1:0] readData2;
    eStage_t         decD;
    eStage_t         eReg;

    assign opcode = instructionF[6:0];
    assign funct3 = instructionF[14:12];
    assign rs1Idx = instructionF[15 +: AW];
    assign rs2Idx = instructionF[20 +: AW];
    assign rdIdx  = instructionF[7 +: AW];

    assign immI = {{20{instructionF[31]}}, instructionF[31:20]};
    assign immS = {{20{instructionF[31]}}, instructionF[31:25], instructionF[11:7]};
    assign immB = {{19{instructionF[31]}}, instructionF[31], instructionF[7],
                   instructionF[30:25], instructionF[11:8], 1'b0};
    assign immU = {instructionF[31:12], 12'b0};
    assign immJ = {{11{instructionF[31]}}, instructionF[31], instructionF[19:12],
                   instructionF[20], instructionF[30:21], 1'b0};

    // Register 0 is never written, so its reset value of 0 is permanent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (RegWriteW && (WriteAddressW != '0)) begin
            regs[WriteAddressW] <= writeDataW;
        end
    end

    always_comb begin
        readData1 = (rs1Idx == '0) ? '0 : regs[rs1Idx];
        readData2 = (rs2Idx == '0) ? '0 : regs[rs2Idx];
`ifdef DECODE_WRITE_BYPASS_EN
        if (RegWriteW && (WriteAddressW != '0) && (WriteAddressW == rs1Idx)) readData1 = writeDataW;
        if (RegWriteW && (WriteAddressW != '0) && (WriteAddressW == rs2Idx)) readData2 = writeDataW;
`endif
    end

    always_comb begin
        imm32       = '0;
        decD        = '0;
        decD.valid  = 1'b1;
        decD.pc     = PCF;
        decD.rd1    = readData1;
        decD.rd2    = readData2;
        decD.rs1    = rs1Idx;
        decD.rs2    = rs2Idx;
        decD.rd     = rdIdx;
        case (opcode)
            OP_R: begin
                decD.regWrite = 1'b1;
                decD.aluSel   = {instructionF[25], instructionF[30], funct3, 1'b0};
            end
            OP_IMM: begin
                decD.regWrite = 1'b1;
                decD.immSel   = 1'b1;
                // Only SRAI uses bit 30 of the immediate as an opcode modifier.
                decD.aluSel   = {1'b0, instructionF[30] & (funct3 == 3'b101), funct3, 1'b0};
                imm32         = immI;
            end
            OP_LOAD: begin
                decD.regWrite = 1'b1;
                decD.memRead  = 1'b1;
                decD.immSel   = 1'b1;
                imm32         = immI;
            end
            OP_STORE: begin
                decD.memWrite = 1'b1;
                decD.immSel   = 1'b1;
                imm32         = immS;
            end
            OP_BRANCH: begin
                decD.branch   = 1'b1;
                decD.aluSel   = {3'b000, funct3, 1'b1};
                imm32         = immB;
            end
            OP_JAL: begin
                decD.regWrite = 1'b1;
                decD.jtype    = 1'b1;
                decD.pcSel    = 1'b1;
                imm32         = immJ;
            end
            OP_JALR: begin
                decD.regWrite = 1'b1;
                decD.jtype    = 1'b1;
                decD.immSel   = 1'b1;
                imm32         = immI;
            end
            OP_LUI: begin
                decD.regWrite = 1'b1;
                decD.immSel   = 1'b1;
                imm32         = immU;
            end
            OP_AUIPC: begin
                decD.regWrite = 1'b1;
                decD.immSel   = 1'b1;
                decD.pcSel    = 1'b1;
                imm32         = immU;
            end
            default: decD.illegal = 1'b1;
        endcase
        decD.imm = XLEN'($signed(imm32));
    end

    assign stallF = validF & eReg.valid & eReg.memRead & (eReg.rd != '0) &
                    ((eReg.rd == rs1Idx) | (eReg.rd == rs2Idx)) & ~flushE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eReg <= '0;
        end else if (flushE || stallF || !validF) begin
            eReg <= '0;
        end else begin
            eReg <= decD;
        end
    end

    assign validE        = eReg.valid;
    assign PCE           = eReg.pc;
    assign ReadOut1E     = eReg.rd1;
    assign ReadOut2E     = eReg.rd2;
    assign ImmGenOutE    = eReg.imm;
    assign Rs1E          = eReg.rs1;
    assign Rs2E          = eReg.rs2;
    assign WriteAddressE = eReg.rd;
    assign ALUSelectE    = eReg.aluSel;
    assign RegWriteE     = eReg.regWrite;
    assign MemReadE      = eReg.memRead;
    assign MemWriteE     = eReg.memWrite;
    assign ImmSelectE    = eReg.immSel;
    assign PCSelectE     = eReg.pcSel;
    assign JtypeE        = eReg.jtype;
    assign BranchE       = eReg.branch;
    assign IllegalE      = eReg.illegal;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Scoreboard bench for decode_pipe_stage: directed corner cases, then randomized traffic with async resets mid-run.
module tb_decode_pipe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instructionF;
    logic [31:0] PCF;
    logic        validF;
    logic        flushE;
    logic        RegWriteW;
    logic [4:0]  WriteAddressW;
    logic [31:0] writeDataW;
    logic        stallF;
    logic        validE;
    logic [31:0] PCE, ReadOut1E, ReadOut2E, ImmGenOutE;
    logic [4:0]  Rs1E, Rs2E, WriteAddressE;
    logic [5:0]  ALUSelectE;
    logic        RegWriteE, MemReadE, MemWriteE, ImmSelectE, PCSelectE, JtypeE, BranchE, IllegalE;

    always #5 clk = ~clk;

    decode_pipe_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .instructionF(instructionF), .PCF(PCF), .validF(validF),
        .flushE(flushE), .RegWriteW(RegWriteW), .WriteAddressW(WriteAddressW), .writeDataW(writeDataW),
        .stallF(stallF), .validE(validE), .PCE(PCE), .ReadOut1E(ReadOut1E), .ReadOut2E(ReadOut2E),
        .ImmGenOutE(ImmGenOutE), .Rs1E(Rs1E), .Rs2E(Rs2E), .WriteAddressE(WriteAddressE),
        .ALUSelectE(ALUSelectE), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
        .ImmSelectE(ImmSelectE), .PCSelectE(PCSelectE), .JtypeE(JtypeE), .BranchE(BranchE),
        .IllegalE(IllegalE)
    );

    typedef struct {
        logic        stall;
        logic        valid;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rs1, rs2, wa;
        logic [5:0]  alu;
        logic        rw, mr, mw, is, ps, jt, br, il;
    } rec_t;

    rec_t        sbq[$];
    rec_t        mE;
    logic [31:0] regsM [32];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] readM(input logic [4:0] a, input logic rw, input logic [4:0] wa,
                                          input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_WRITE_BYPASS_EN
        if (rw && wa == a) return wd;
`endif
        return regsM[a];
    endfunction

    // Reference decode straight from the instruction-set tables, immediates by integer arithmetic.
    function automatic rec_t modelDecode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] v1, input logic [31:0] v2);
        rec_t       r;
        logic [6:0] ctl;
        int         s, f3, imm, alu;
        logic       ill;
        r   = '{default: '0};
        s   = ins;
        f3  = int'(ins[14:12]);
        imm = 0;
        alu = 0;
        ill = 1'b0;
        ctl = 7'b0;  // {RegWrite, MemRead, MemWrite, ImmSelect, PCSelect, Jtype, Branch}
        case (ins[6:0])
            7'b0110011: begin ctl = 7'b1000000; alu = int'(ins[25]) * 32 + int'(ins[30]) * 16 + f3 * 2; end
            7'b0010011: begin ctl = 7'b1001000; imm = s >>> 20;
                              alu = ((ins[30] && f3 == 5) ? 16 : 0) + f3 * 2; end
            7'b0000011: begin ctl = 7'b1101000; imm = s >>> 20; end
            7'b0100011: begin ctl = 7'b0011000; imm = (s >>> 25) * 32 + int'(ins[11:7]); end
            7'b1100011: begin ctl = 7'b0000001; alu = f3 * 2 + 1;
                              imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                                    + int'(ins[11:8]) * 2; end
            7'b1101111: begin ctl = 7'b1000110;
                              imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                                    + int'(ins[30:21]) * 2; end
            7'b1100111: begin ctl = 7'b1001010; imm = s >>> 20; end
            7'b0110111: begin ctl = 7'b1001000; imm = int'(ins & 32'hFFFFF000); end
            7'b0010111: begin ctl = 7'b1001100; imm = int'(ins & 32'hFFFFF000); end
            default:    ill = 1'b1;
        endcase
        r.valid = 1'b1;
        r.pc  = pc;   r.r1 = v1;  r.r2 = v2;  r.imm = 32'(imm);
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.wa = ins[11:7];
        r.alu = 6'(alu);
        {r.rw, r.mr, r.mw, r.is, r.ps, r.jt, r.br} = ctl;
        r.il  = ill;
        return r;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic vf, input logic fl,
                         input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                         output logic stallExp);
        rec_t nxt;
        @(negedge clk);
        reset = 1'b1;
        instructionF = ins; PCF = pc; validF = vf; flushE = fl;
        RegWriteW = rw; WriteAddressW = wa; writeDataW = wd;
        stallExp = vf && mE.valid && mE.mr && mE.wa != 5'd0 &&
                   (mE.wa == ins[19:15] || mE.wa == ins[24:20]) && !fl;
        if (fl || stallExp || !vf) nxt = '{default: '0};
        else nxt = modelDecode(ins, pc, readM(ins[19:15], rw, wa, wd), readM(ins[24:20], rw, wa, wd));
        nxt.stall = stallExp;
        sbq.push_back(nxt);
        mE = nxt;
        if (rw && wa != 5'd0) regsM[wa] = wd;
    endtask

    task automatic checkZero(input string tag);
        chk({tag, ".stallF"}, 32'(stallF), 32'd0);
        chk({tag, ".validE"}, 32'(validE), 32'd0);
        chk({tag, ".data"}, PCE | ReadOut1E | ReadOut2E | ImmGenOutE, 32'd0);
        chk({tag, ".addr"}, 32'({Rs1E, Rs2E, WriteAddressE, ALUSelectE}), 32'd0);
        chk({tag, ".ctl"}, 32'({RegWriteE, MemReadE, MemWriteE, ImmSelectE, PCSelectE, JtypeE,
                                BranchE, IllegalE}), 32'd0);
    endtask

    task automatic holdReset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            instructionF = $urandom; PCF = $urandom; validF = 1'b1; flushE = 1'b0;
            RegWriteW = 1'b1; WriteAddressW = 5'($urandom_range(1, 31)); writeDataW = $urandom;
            #2 checkZero("rstHold");
        end
        mE = '{default: '0};
        foreach (regsM[i]) regsM[i] = 32'd0;
    endtask

    task automatic doReset();
        @(negedge clk);
        #3 reset = 1'b0;
        #1 checkZero("rstAsync");
        holdReset(2);
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 12))
            0:       ins[6:0] = 7'b0110011;
            1:       ins[6:0] = 7'b0010011;
            2, 3, 4: ins[6:0] = 7'b0000011;
            5:       ins[6:0] = 7'b0100011;
            6:       ins[6:0] = 7'b1100011;
            7:       ins[6:0] = 7'b1101111;
            8:       ins[6:0] = 7'b1100111;
            9:       ins[6:0] = 7'b0110111;
            10:      ins[6:0] = 7'b0010111;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) begin
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
        end
        return ins;
    endfunction

    initial begin : monitor
        rec_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("stallF", 32'(stallF), 32'(e.stall));
                @(posedge clk);
                #1;
                chk("validE", 32'(validE), 32'(e.valid));
                chk("PCE", PCE, e.pc);
                chk("ReadOut1E", ReadOut1E, e.r1);
                chk("ReadOut2E", ReadOut2E, e.r2);
                chk("ImmGenOutE", ImmGenOutE, e.imm);
                chk("Rs1E", 32'(Rs1E), 32'(e.rs1));
                chk("Rs2E", 32'(Rs2E), 32'(e.rs2));
                chk("WriteAddressE", 32'(WriteAddressE), 32'(e.wa));
                chk("ALUSelectE", 32'(ALUSelectE), 32'(e.alu));
                chk("RegWriteE", 32'(RegWriteE), 32'(e.rw));
                chk("MemReadE", 32'(MemReadE), 32'(e.mr));
                chk("MemWriteE", 32'(MemWriteE), 32'(e.mw));
                chk("ImmSelectE", 32'(ImmSelectE), 32'(e.is));
                chk("PCSelectE", 32'(PCSelectE), 32'(e.ps));
                chk("JtypeE", 32'(JtypeE), 32'(e.jt));
                chk("BranchE", 32'(BranchE), 32'(e.br));
                chk("IllegalE", 32'(IllegalE), 32'(e.il));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        logic        st;
        logic        curV;
        logic [31:0] curI, curPC, oldX3;
        reset = 1'b0;
        instructionF = $urandom; PCF = $urandom; validF = 1'b1; flushE = 1'b0;
        RegWriteW = 1'b1; WriteAddressW = 5'd7; writeDataW = $urandom;
        mE = '{default: '0};
        foreach (regsM[i]) regsM[i] = 32'd0;
        holdReset(3);

        // addi x1,x0,5 right after reset release
        drive(32'h00500093, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        @(posedge clk); #2;
        chk("addi.RegWriteE", 32'(RegWriteE), 32'd1);
        chk("addi.ImmSelectE", 32'(ImmSelectE), 32'd1);
        chk("addi.ImmGenOutE", ImmGenOutE, 32'd5);
        chk("addi.validE", 32'(validE), 32'd1);

        // lw x5,0(x2) then add x6,x5,x7: one stall cycle, then the add enters E
        drive(32'h00012283, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        drive(32'h00728333, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        #2 chk("lu.stallF", 32'(stallF), 32'd1);
        @(posedge clk); #2;
        chk("lu.bubble", 32'(validE), 32'd0);
        drive(32'h00728333, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        #2 chk("lu.noStall", 32'(stallF), 32'd0);
        @(posedge clk); #2;
        chk("lu.validE", 32'(validE), 32'd1);
        chk("lu.Rs1E", 32'(Rs1E), 32'd5);

        // flush beats a pending load-use hazard
        drive(32'h00012283, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        drive(32'h00512023, 32'h110, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, st);
        #2 chk("flush.stallF", 32'(stallF), 32'd0);
        @(posedge clk); #2;
        chk("flush.validE", 32'(validE), 32'd0);
        chk("flush.MemWriteE", 32'(MemWriteE), 32'd0);

        // same-cycle write/read of x3, then writes to x0
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h12345678, st);
        drive(32'h00018233, 32'h114, 1'b1, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, st);
`ifdef DECODE_WRITE_BYPASS_EN
        oldX3 = 32'hDEADBEEF;
`else
        oldX3 = 32'h12345678;
`endif
        @(posedge clk); #2;
        chk("byp.sameCycle", ReadOut1E, oldX3);
        drive(32'h00018233, 32'h118, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, st);
        @(posedge clk); #2;
        chk("byp.nextCycle", ReadOut1E, 32'hDEADBEEF);
        drive(32'h00000233, 32'h11C, 1'b1, 1'b0, 1'b1, 5'd0, 32'hCAFEF00D, st);
        @(posedge clk); #2;
        chk("x0.read", ReadOut1E, 32'd0);

        // immediate extremes and an illegal opcode
        drive(32'h80000063, 32'h120, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        @(posedge clk); #2;
        chk("beq.imm", ImmGenOutE, 32'hFFFFF000);
        chk("beq.BranchE", 32'(BranchE), 32'd1);
        chk("beq.ALUSelectE", 32'(ALUSelectE), 32'd1);
        drive(32'h7FFFF0EF, 32'h124, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        @(posedge clk); #2;
        chk("jal.imm", ImmGenOutE, 32'h000FFFFE);
        drive(32'h00000000, 32'h128, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
        @(posedge clk); #2;
        chk("ill.IllegalE", 32'(IllegalE), 32'd1);
        chk("ill.RegWriteE", 32'(RegWriteE), 32'd0);

        // randomized traffic; a stalled instruction is re-presented as fetch would
        st = 1'b0;
        curI = 32'd0; curPC = 32'd0; curV = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1000 || n == 2000) begin
                doReset();
                st = 1'b0;
            end
            if (!st) begin
                curI  = randInstr();
                curPC = $urandom & ~32'd3;
                curV  = ($urandom_range(0, 9) != 0);
            end
            drive(curI, curPC, curV, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom, st);
        end

        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width of register data, PC and immediate.
REQ-002 SHALL have parameter NREGS, default 32: register count (power of 2, 2..32); index width AW = clog2(NREGS).
REQ-003 SHALL have ports, in this order:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instructionF  in  32  instruction from fetch.
- PCF  in  XLEN  PC of instructionF.
- validF  in  1  instructionF is a real instruction.
- flushE  in  1  taken branch/jump in E; kill the instruction entering E.
- RegWriteW  in  1  writeback enable.
- WriteAddressW  in  AW  writeback destination.
- writeDataW  in  XLEN  writeback data.
- stallF  out  1  hold fetch and the instructionF/PCF inputs (load-use).
- validE  out  1  E-stage instruction is live.
- PCE, ReadOut1E, ReadOut2E, ImmGenOutE  out  XLEN  registered PC, operands, immediate.
- Rs1E, Rs2E, WriteAddressE  out  AW  registered instr[19:15], [24:20], [11:7], truncated to AW.
- ALUSelectE  out  6  registered ALU operation.
- RegWriteE, MemReadE, MemWriteE, ImmSelectE, PCSelectE, JtypeE, BranchE, IllegalE  out  1 each  registered controls.

Function
REQ-004 SHALL decode opcode instr[6:0] into controls; any bit not listed is 0:
- 0110011 RegWrite
- 0010011 RegWrite, ImmSelect
- 0000011 RegWrite, MemRead, ImmSelect
- 0100011 MemWrite, ImmSelect
- 1100011 Branch
- 1101111 RegWrite, Jtype, PCSelect
- 1100111 RegWrite, Jtype, ImmSelect
- 0110111 RegWrite, ImmSelect
- 0010111 RegWrite, ImmSelect, PCSelect
- any other opcode: Illegal=1, all other controls 0.
REQ-005 SHALL set ALUSelect = {instr[25]&R, instr[30]&(R | (OP-IMM & funct3==101)), funct3, 1'b0} for R/OP-IMM, {3'b000, funct3, 1'b1} for Branch, and 6'b0 (ADD) otherwise.
REQ-006 SHALL generate immediates sign-extended to XLEN: I (OP-IMM, load, JALR), S, B (bit0=0), U (low 12 bits 0), J (bit0=0); R-type and illegal produce 0.
REQ-007 SHALL hold NREGS x XLEN registers; register 0 reads 0 and ignores writes; write occurs on rising clk when RegWriteW=1.
REQ-008 SHALL read both operands combinationally from instructionF index fields and capture them in the E register.
REQ-009 SHALL assert stallF combinationally when validF & validE & MemReadE & WriteAddressE!=0 & (WriteAddressE==rs1 | WriteAddressE==rs2) & !flushE.
REQ-010 SHALL load the E register per cycle with this priority: flushE -> bubble; stallF -> bubble; else decoded instructionF with validE=validF.
REQ-011 SHALL make a bubble validE=0, all control outputs 0, and data/address outputs don't-care (implementation drives 0).
REQ-012 SHALL give latency exactly 1 cycle from instructionF to E outputs; stallF holds at most 1 cycle per load-use pair.
REQ-013 SHALL gate all E controls with validF: validF=0 yields a bubble.

Reset
REQ-014 SHALL, while reset=0 (asynchronous), force every E output to 0, validE=0, stallF=0, and all registers to 0.
REQ-015 SHALL, when reset asserts mid-operation, discard any in-flight E contents with no partial write; the first post-release edge loads normally.

Configuration
REQ-016 SHALL support macro DECODE_WRITE_BYPASS_EN: when defined, a read of an index equal to WriteAddressW (non-zero, RegWriteW=1) in the same cycle SHALL return writeDataW. When undefined, such a read SHALL return the pre-write value, and the E-stage forwarding unit covers the case.

Verification
REQ-017 SHALL cover reset: reset=0 with random inputs -> all outputs 0; release, then addi x1,x0,5 -> next cycle RegWriteE=1, ImmSelectE=1, ImmGenOutE=5, validE=1.
REQ-018 SHALL cover load-use: lw x5,0(x2), then add x6,x5,x7 -> cycle 2 stallF=1 with bubble in E; cycle 3 add in E, Rs1E=5.
REQ-019 SHALL cover flush: flushE=1 together with a valid sw -> next cycle validE=0, MemWriteE=0, stallF=0 even if a load-use condition exists.
REQ-020 SHALL cover bypass: RegWriteW=1, WriteAddressW=3, writeDataW=0xDEADBEEF while decoding add x4,x3,x0 -> ReadOut1E=0xDEADBEEF with macro defined, old x3 without; a write to x0 -> reads 0.
REQ-021 SHALL cover immediate boundaries: beq offset -4096 -> ImmGenOutE=0xFFFFF000, BranchE=1, ALUSelectE=6'b000001; jal offset +1048574 -> 0x000FFFFE; opcode 0000000 -> IllegalE=1, RegWriteE=0.
